// File: rtl/led_demux.sv
// led_demux: reconstructs eight static digit patterns from a time-multiplexed
// LED segment/select bus.
//
// The bus is registered once. A sample is evaluated only after it has
// remained unchanged for SETTLE consecutive samples, which rejects glitches
// and ghosting during select transitions. An evaluated sample with exactly
// one select bit low loads that digit's output register. A frame is complete
// once all eight digits have been captured.
//
// Parameters:
//   SETTLE     1..255, consecutive identical samples required before a capture
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      synchronous active-low reset
//   seg_in     [7:0] multiplexed segment bus, active-low
//   sel_in     [7:0] digit select, active-low one-hot (bit i low = digit i)
//   clr_err    single-cycle request to clear sel_err
//   out0..out7 [7:0] reconstructed segment pattern per digit, raw active-low
//   valid      sticky: a complete frame has been captured since reset
//   frame_done one-cycle pulse when the eighth distinct digit of a frame lands
//   sel_err    sticky: a stable sample had more than one select bit low
//   err_cnt    [7:0] saturating count of multi-select evaluations
//              (present only when LED_DEMUX_ERR_CNT_EN is defined)
//
// Build option: define LED_DEMUX_ERR_CNT_EN to add the err_cnt output.

module led_demux #(
  parameter int unsigned SETTLE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg_in,
  input  logic [7:0] sel_in,
  input  logic       clr_err,
  output logic [7:0] out0,
  output logic [7:0] out1,
  output logic [7:0] out2,
  output logic [7:0] out3,
  output logic [7:0] out4,
  output logic [7:0] out5,
  output logic [7:0] out6,
  output logic [7:0] out7,
  output logic       valid,
  output logic       frame_done,
  output logic       sel_err
`ifdef LED_DEMUX_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam int unsigned DW   = 8;
  localparam int unsigned NDIG = 8;
  localparam int unsigned CW   = 8;
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);

  // Sample stage
  logic [DW-1:0]   seg_q, seg_d;
  logic [NDIG-1:0] sel_q, sel_d;

  // Stability tracking
  logic [CW-1:0]   cnt_q, cnt_d;

  // Digit capture and frame tracking
  logic [DW-1:0]   out_q [NDIG];
  logic [DW-1:0]   out_d [NDIG];
  logic [NDIG-1:0] seen_q, seen_d;
  logic            valid_q, valid_d;
  logic            frame_done_q, frame_done_d;
  logic            sel_err_q, sel_err_d;

`ifdef LED_DEMUX_ERR_CNT_EN
  logic [CW-1:0]   err_cnt_q, err_cnt_d;
`endif

  // Evaluation decode
  logic            stable_c;
  logic            eval_c;
  logic [NDIG-1:0] sel_low_c;
  logic            sel_none_c;
  logic            sel_single_c;
  logic            capture_c;
  logic            err_evt_c;
  logic [NDIG-1:0] seen_acc_c;

  // Counter tracks how many edges the held sample has matched the bus.
  // It reaches SETTLE on the edge that samples the value for the
  // SETTLE+1-th time, and that same edge performs the capture, so the
  // decision is made from cnt_q == SETTLE-1 plus a still-matching bus.
  always_comb begin
    stable_c = (seg_in == seg_q) && (sel_in == sel_q);
    eval_c   = stable_c && (cnt_q == (SETTLE_C - CW'(1)));

    sel_low_c    = ~sel_q;
    sel_none_c   = (sel_low_c == '0);
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    sel_single_c = !sel_none_c && ((sel_low_c & (sel_low_c - NDIG'(1))) == '0);

    capture_c = eval_c && sel_single_c;
    err_evt_c = eval_c && !sel_none_c && !sel_single_c;
  end

  // Next-state logic
  always_comb begin
    seg_d        = seg_in;
    sel_d        = sel_in;
    cnt_d        = cnt_q;
    seen_d       = seen_q;
    valid_d      = valid_q;
    frame_done_d = 1'b0;
    sel_err_d    = sel_err_q;
    seen_acc_c   = seen_q;
    for (int i = 0; i < NDIG; i++) begin
      out_d[i] = out_q[i];
    end

    // Saturating stability counter
    if (!stable_c) begin
      cnt_d = '0;
    end else if (cnt_q != SETTLE_C) begin
      cnt_d = cnt_q + CW'(1);
    end

    // Capture into the selected digit; frame completes when every digit seen
    if (capture_c) begin
      for (int i = 0; i < NDIG; i++) begin
        if (sel_low_c[i]) begin
          out_d[i] = seg_q;
        end
      end
      seen_acc_c = seen_q | sel_low_c;
      if (seen_acc_c == '1) begin
        frame_done_d = 1'b1;
        valid_d      = 1'b1;
        seen_d       = '0;
      end else begin
        seen_d = seen_acc_c;
      end
    end

    // A new error evaluation takes priority over a clear request
    if (err_evt_c) begin
      sel_err_d = 1'b1;
    end else if (clr_err) begin
      sel_err_d = 1'b0;
    end
  end

`ifdef LED_DEMUX_ERR_CNT_EN
  // Error counter: increment wins over clear, restarting the count at one
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_evt_c) begin
      if (clr_err) begin
        err_cnt_d = CW'(1);
      end else if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + CW'(1);
      end
    end else if (clr_err) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q        <= '1;
      sel_q        <= '1;
      cnt_q        <= '0;
      seen_q       <= '0;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
      sel_err_q    <= 1'b0;
      for (int i = 0; i < NDIG; i++) begin
        out_q[i] <= '1;
      end
    end else begin
      seg_q        <= seg_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      seen_q       <= seen_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
      sel_err_q    <= sel_err_d;
      for (int i = 0; i < NDIG; i++) begin
        out_q[i] <= out_d[i];
      end
    end
  end

  assign out0       = out_q[0];
  assign out1       = out_q[1];
  assign out2       = out_q[2];
  assign out3       = out_q[3];
  assign out4       = out_q[4];
  assign out5       = out_q[5];
  assign out6       = out_q[6];
  assign out7       = out_q[7];
  assign valid      = valid_q;
  assign frame_done = frame_done_q;
  assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_led_demux.sv
// tb_led_demux: directed stimulus for led_demux with a behavioural model
// checked every cycle plus literal expectations at key points.

module tb_led_demux;

  localparam int SETTLE = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] seg_in;
  logic [7:0] sel_in;
  logic       clr_err;
  logic [7:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic       valid;
  logic       frame_done;
  logic       sel_err;
`ifdef LED_DEMUX_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  always #5 clk = ~clk;

  led_demux #(.SETTLE(SETTLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .sel_in     (sel_in),
    .clr_err    (clr_err),
    .out0       (out0),
    .out1       (out1),
    .out2       (out2),
    .out3       (out3),
    .out4       (out4),
    .out5       (out5),
    .out6       (out6),
    .out7       (out7),
    .valid      (valid),
    .frame_done (frame_done),
    .sel_err    (sel_err)
`ifdef LED_DEMUX_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  logic [7:0] dut_out [8];
  assign dut_out[0] = out0;
  assign dut_out[1] = out1;
  assign dut_out[2] = out2;
  assign dut_out[3] = out3;
  assign dut_out[4] = out4;
  assign dut_out[5] = out5;
  assign dut_out[6] = out6;
  assign dut_out[7] = out7;

  int n_vec  = 0;
  int n_err  = 0;
  int fd_cnt = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dsel(input int i);
    logic [7:0] one;
    one = 8'd1;
    return ~(one << i);
  endfunction

  // Behavioural model: a value presented on the raw bus for SETTLE+1
  // consecutive rising edges is acted upon at the last of those edges.
  logic [7:0] m_out [8];
  logic       m_valid, m_fd, m_err;
  logic [7:0] m_seen;
  logic [7:0] m_seg, m_sel;
  logic [7:0] m_ecnt;
  int         run;
  bit         m_live = 1'b0;

  always @(posedge clk) begin : model_p
    logic [7:0] low;
    int         nlow;
    bit         ev;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_out[i] = 8'hFF;
      m_valid = 1'b0;
      m_fd    = 1'b0;
      m_err   = 1'b0;
      m_seen  = 8'h00;
      m_ecnt  = 8'h00;
      m_seg   = 8'hFF;
      m_sel   = 8'hFF;
      run     = 1;
    end else begin
      m_fd = 1'b0;
      if (seg_in == m_seg && sel_in == m_sel) begin
        if (run <= SETTLE + 1) run++;
      end else begin
        run   = 1;
        m_seg = seg_in;
        m_sel = sel_in;
      end
      ev   = (run == SETTLE + 1);
      low  = ~m_sel;
      nlow = $countones(low);
      if (ev && nlow == 1) begin
        for (int i = 0; i < 8; i++) begin
          if (low[i]) begin
            m_out[i]  = m_seg;
            m_seen[i] = 1'b1;
          end
        end
        if (m_seen == 8'hFF) begin
          m_fd    = 1'b1;
          m_valid = 1'b1;
          m_seen  = 8'h00;
        end
      end
      if (ev && nlow >= 2) m_err = 1'b1;
      else if (clr_err)    m_err = 1'b0;
      if (ev && nlow >= 2) m_ecnt = clr_err ? 8'd1 : (m_ecnt == 8'hFF ? 8'hFF : m_ecnt + 8'd1);
      else if (clr_err)    m_ecnt = 8'h00;
    end
    m_live = 1'b1;
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (m_live) begin
      for (int i = 0; i < 8; i++) chk($sformatf("cyc_out%0d", i), dut_out[i], m_out[i]);
      chk("cyc_valid", 8'(valid), 8'(m_valid));
      chk("cyc_frame_done", 8'(frame_done), 8'(m_fd));
      chk("cyc_sel_err", 8'(sel_err), 8'(m_err));
`ifdef LED_DEMUX_ERR_CNT_EN
      chk("cyc_err_cnt", err_cnt, m_ecnt);
`endif
      if (frame_done === 1'b1) fd_cnt++;
    end
  end

  task automatic drive(input logic [7:0] s, input logic [7:0] l, input int n);
    seg_in = s;
    sel_in = l;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n  = 1'b0;
    seg_in = 8'h00;
    sel_in = 8'h00;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [7:0] tbl  [8];
  logic [7:0] tbl2 [8];
  int         fd0;

  initial begin
    tbl  = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
    tbl2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    rst_n   = 1'b0;
    seg_in  = 8'h00;
    sel_in  = 8'h00;
    clr_err = 1'b0;

    // Reset state while the bus carries junk
    do_reset(2);
    for (int i = 0; i < 8; i++) chk($sformatf("rst_out%0d", i), dut_out[i], 8'hFF);
    chk("rst_valid", 8'(valid), 8'h00);
    chk("rst_frame_done", 8'(frame_done), 8'h00);
    chk("rst_sel_err", 8'(sel_err), 8'h00);

    // Glitch shorter than the settle window is discarded
    drive(8'h80, 8'hFD, 3);
    drive(8'hFF, 8'hFF, 8);
    chk("glitch_out1", out1, 8'hFF);
    chk("glitch_err", 8'(sel_err), 8'h00);

    // Full frame, with the capture latency pinned on digit 0
    fd0 = fd_cnt;
    drive(tbl[0], dsel(0), SETTLE);
    chk("lat_before", out0, 8'hFF);
    drive(tbl[0], dsel(0), 1);
    chk("lat_after", out0, 8'hC0);
    drive(tbl[0], dsel(0), 3);
    for (int i = 1; i < 8; i++) drive(tbl[i], dsel(i), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("frame_out%0d", i), dut_out[i], tbl[i]);
    chk("frame_valid", 8'(valid), 8'h01);
    chk("frame_pulses", 8'(fd_cnt - fd0), 8'd1);

    // Multi-select error, clear, and clear coincident with a new error
    drive(8'hC0, 8'hFC, 6);
    chk("err_set", 8'(sel_err), 8'h01);
    chk("err_out0", out0, 8'hC0);
    chk("err_out1", out1, 8'hF9);
    drive(8'hFF, 8'hFF, 6);
    clr_err = 1'b1;
    drive(8'hFF, 8'hFF, 1);
    clr_err = 1'b0;
    chk("err_cleared", 8'(sel_err), 8'h00);
    drive(8'hC0, 8'hFC, SETTLE);
    clr_err = 1'b1;
    drive(8'hC0, 8'hFC, 1);
    clr_err = 1'b0;
    chk("err_clr_coincident", 8'(sel_err), 8'h01);
    drive(8'hFF, 8'hFF, 6);
    clr_err = 1'b1;
    drive(8'hFF, 8'hFF, 1);
    clr_err = 1'b0;

    // Reset mid-frame discards partial progress
    do_reset(2);
    fd0 = fd_cnt;
    for (int i = 0; i < 4; i++) drive(tbl2[i], dsel(i), 8);
    do_reset(1);
    for (int i = 4; i < 8; i++) drive(tbl2[i], dsel(i), 8);
    chk("midrst_no_frame", 8'(fd_cnt - fd0), 8'd0);
    chk("midrst_valid", 8'(valid), 8'h00);
    chk("midrst_out0", out0, 8'hFF);
    drive(tbl2[0], dsel(0), 8);
    drive(tbl2[1], dsel(1), 8);
    drive(8'h5A, dsel(2), 8);
    drive(tbl2[2], dsel(2), 8);
    for (int i = 3; i < 8; i++) drive(tbl2[i], dsel(i), 8);
    chk("midrst_frame", 8'(fd_cnt - fd0), 8'd1);
    chk("midrst_valid2", 8'(valid), 8'h01);
    chk("recapture_out2", out2, 8'h33);

    // Blanking between every digit
    do_reset(2);
    fd0 = fd_cnt;
    for (int i = 0; i < 8; i++) begin
      drive(tbl[7-i], dsel(i), 8);
      drive(8'hFF, 8'hFF, 6);
    end
    for (int i = 0; i < 8; i++) chk($sformatf("blank_out%0d", i), dut_out[i], tbl[7-i]);
    chk("blank_frame", 8'(fd_cnt - fd0), 8'd1);
    chk("blank_err", 8'(sel_err), 8'h00);
    chk("blank_valid", 8'(valid), 8'h01);

`ifdef LED_DEMUX_ERR_CNT_EN
    // Error counter saturation and clear
    for (int k = 0; k < 150; k++) begin
      drive(8'h00, 8'hFC, SETTLE + 1);
      drive(8'h00, 8'hF3, SETTLE + 1);
    end
    chk("errcnt_sat", err_cnt, 8'hFF);
    drive(8'hFF, 8'hFF, 6);
    clr_err = 1'b1;
    drive(8'hFF, 8'hFF, 1);
    clr_err = 1'b0;
    chk("errcnt_clr", err_cnt, 8'h00);
`endif

    drive(8'hFF, 8'hFF, 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_demux.md
LED_DEMUX -- requirements
Module: led_demux

Interface
REQ-001 SHALL have parameter SETTLE, default 4, range 1..255: consecutive identical registered samples required before a digit capture.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port seg_in  input  8  multiplexed segment bus, active-low, as driven by the display multiplexer.
REQ-005 SHALL have port sel_in  input  8  digit select bus, active-low one-hot; bit i low selects digit i.
REQ-006 SHALL have port clr_err  input  1  single-cycle request to clear sel_err.
REQ-007 SHALL have ports out0..out7  output  8 each  reconstructed segment pattern of digit 0..7, raw active-low.
REQ-008 SHALL have port valid  output  1  high once a complete frame (all 8 digits) has been captured since reset.
REQ-009 SHALL have port frame_done  output  1  one-cycle pulse when the 8th distinct digit of a frame is captured.
REQ-010 SHALL have port sel_err  output  1  sticky flag: sel_in had more than one low bit for SETTLE stable samples.

Function
REQ-011 SHALL register seg_in and sel_in once (sample stage) before any other use.
REQ-012 SHALL keep an 8-bit stability counter: 0 when the sample differs from the previous sample, otherwise increment, saturating at SETTLE.
REQ-013 SHALL evaluate a sample exactly once per stable period, on the cycle the counter first reaches SETTLE.
REQ-014 On evaluation with exactly one sel bit low at index i: outi SHALL load the sampled seg value; other out registers unchanged.
REQ-015 Update latency SHALL be SETTLE+1 rising edges from the first edge at which the new stable value is present on seg_in/sel_in.
REQ-016 On evaluation with sel sample 8'hFF (blanking): no capture, no error, seen mask unchanged.
REQ-017 On evaluation with two or more sel bits low: no capture, sel_err set, seen mask unchanged.
REQ-018 SHALL keep an 8-bit seen mask; bit i set on a capture into outi.
REQ-019 When a capture makes the seen mask all ones: frame_done high for exactly that cycle, valid set (sticky), and the mask SHALL clear to 0 in the same cycle.
REQ-020 A digit recaptured before the frame completes SHALL overwrite outi without affecting mask or frame_done.
REQ-021 clr_err SHALL clear sel_err on the next edge; if a new error evaluation occurs on the same cycle, sel_err SHALL remain set.
REQ-022 A sample change before the counter reaches SETTLE SHALL discard the pending value (glitch/ghost rejection); no capture.

Reset
REQ-023 rst_n low at a rising edge SHALL set out0..out7 = 8'hFF, valid = 0, frame_done = 0, sel_err = 0, seen mask = 0, stability counter = 0, sample registers = 8'hFF.
REQ-024 Reset asserted mid-frame SHALL discard partial progress; the first frame after reset SHALL require all 8 digits again.
REQ-025 With rst_n low, all outputs SHALL hold reset values regardless of seg_in/sel_in.

Configuration
REQ-026 Macro LED_DEMUX_ERR_CNT_EN SHALL control an error counter.
REQ-027 Defined: SHALL add output err_cnt (8 bits), incremented on each REQ-017 evaluation, saturating at 8'hFF, cleared by reset and by clr_err; increment wins over clear on the same cycle (result 1 if counter was any value).
REQ-028 Undefined: err_cnt port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 Drive sel=8'hFE..8'h7F in order, seg=8'hC0,F9,A4,B0,99,92,82,F8, each held 8 cycles, SETTLE=4 -> out0..out7 equal those values, one frame_done pulse after digit 7, valid=1.
REQ-030 sel=8'hFD, seg=8'h80 held 3 cycles then changed, SETTLE=4 -> out1 stays 8'hFF, mask unchanged.
REQ-031 sel=8'hFC held 6 cycles -> sel_err=1, no out change; clr_err pulse -> sel_err=0; clr_err coincident with new error -> sel_err stays 1.
REQ-032 Capture digits 0..3, assert rst_n low 1 cycle, then digits 4..7 -> no frame_done; full 8 further digits -> frame_done and valid=1.
REQ-033 sel=8'hFF between every digit, full frame -> no error, frame_done once, outputs correct.
REQ-034 With LED_DEMUX_ERR_CNT_EN: 300 multi-low evaluations -> err_cnt=8'hFF; clr_err -> 0; without macro, bench compiles without err_cnt.
